// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared types and helpers for the instruction fetch path
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    WAIT_GNT       = 2'd1,
    WAIT_GNT_FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] FETCH_WORD_BYTES = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/cv32e40p_fetch_fifo.sv
// rtl/cv32e40p_fetch_fifo.sv - synchronous instruction word FIFO with clear, no bypass
module cv32e40p_fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [31:0]              wdata_i,
  input  logic                     pop_i,
  output logic [31:0]              rdata_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             pop_ok;

  assign pop_ok = pop_i && (cnt_q != '0);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_ok) rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/cv32e40p_fetch_buffer.sv
// rtl/cv32e40p_fetch_buffer.sv - instruction prefetch buffer between IF stage and instruction bus
module cv32e40p_fetch_buffer
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [31:0]      out_addr_q, out_addr_d;
  logic [31:0]      br_addr_q, br_addr_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] fifo_cnt;
  logic [31:0]      target;
  logic             credit, gnt_accept, push, pop;

  assign target = word_align(branch_addr_i);

  // Reserving FIFO room for every in-flight word means a push can never hit a full FIFO.
  assign credit = req_i
               && (int'(outstanding_q) < MAX_OUTSTANDING)
               && (int'(fifo_cnt) + int'(outstanding_q) < DEPTH);

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    br_addr_d   = br_addr_q;
    instr_req_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_req_o = credit && !branch_i;
        if (instr_req_o) begin
          if (instr_gnt_i) req_addr_d = req_addr_q + FETCH_WORD_BYTES;
          else             state_d    = WAIT_GNT;
        end
        if (branch_i) req_addr_d = target;
      end
      WAIT_GNT: begin
        // The bus forbids changing the address of an ungranted request.
        instr_req_o = 1'b1;
        if (instr_gnt_i) begin
          state_d    = IDLE;
          req_addr_d = branch_i ? target : req_addr_q + FETCH_WORD_BYTES;
        end else if (branch_i) begin
          state_d   = WAIT_GNT_FLUSH;
          br_addr_d = target;
        end
      end
      WAIT_GNT_FLUSH: begin
        instr_req_o = 1'b1;
        if (branch_i) br_addr_d = target;
        if (instr_gnt_i) begin
          state_d    = IDLE;
          req_addr_d = branch_i ? target : br_addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_accept = instr_req_o && instr_gnt_i;
  assign push       = instr_rvalid_i && (drop_cnt_q == '0) && !branch_i;
  assign pop        = fetch_valid_o && fetch_ready_i && !branch_i;

  always_comb begin
    outstanding_d = outstanding_q + OUT_W'(gnt_accept) - OUT_W'(instr_rvalid_i);
    drop_cnt_d    = drop_cnt_q;
    out_addr_d    = out_addr_q;
    if (branch_i) begin
      // Everything still in flight after this cycle belongs to the old stream.
      drop_cnt_d = outstanding_d;
      out_addr_d = target;
    end else begin
      if (instr_rvalid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_d - 1'b1;
      if ((state_q == WAIT_GNT_FLUSH) && gnt_accept) drop_cnt_d = drop_cnt_d + 1'b1;
      if (pop) out_addr_d = out_addr_q + FETCH_WORD_BYTES;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_addr_q    <= '0;
      out_addr_q    <= '0;
      br_addr_q     <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      out_addr_q    <= out_addr_d;
      br_addr_q     <= br_addr_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  cv32e40p_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (branch_i),
    .push_i  (push),
    .wdata_i (instr_rdata_i),
    .pop_i   (pop),
    .rdata_o (fetch_rdata_o),
    .cnt_o   (fifo_cnt)
  );

  assign fetch_valid_o = (fifo_cnt != '0);
  assign fetch_addr_o  = out_addr_q;
  assign instr_addr_o  = req_addr_q;
  assign busy_o        = (outstanding_q != '0) || instr_req_o;

endmodule

// File: tb/tb_cv32e40p_fetch_buffer.sv
// tb/tb_cv32e40p_fetch_buffer.sv - directed bench with bus model and expected-word scoreboard
module tb_cv32e40p_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_rdata_o;
  logic [31:0] fetch_addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  cv32e40p_fetch_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_addr_o   (fetch_addr_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  int          gnt_hold = 0;
  logic        gnt_en = 1'b1;
  int          grants = 0;
  int          consumed = 0;
  int          first_cons = -1;
  logic [31:0] exp_q [$];
  logic [31:0] bus_a [$];
  int          bus_t [$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_branch(input logic [31:0] t);
    exp_q.delete();
    for (int i = 0; i < 24; i++) exp_q.push_back(t + 32'(4 * i));
    consumed   = 0;
    first_cons = -1;
  endtask

  // One clock: drive bus inputs, sample just before the edge, advance to the next negedge.
  task automatic tick();
    logic [31:0] e;
    instr_gnt_i = gnt_en && (gnt_hold == 0);
    if (bus_a.size() != 0 && bus_t[0] <= cyc) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = data_of(bus_a[0]);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
    end
    #1;
    if (!rst && fetch_valid_o && fetch_ready_i && !branch_i) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("fetch_addr", fetch_addr_o, e);
        chk("fetch_rdata", fetch_rdata_o, data_of(e));
      end
      consumed++;
      if (first_cons < 0) first_cons = cyc;
    end
    if (instr_rvalid_i) begin
      void'(bus_a.pop_front());
      void'(bus_t.pop_front());
    end
    if (!rst && instr_req_o && instr_gnt_i) begin
      bus_a.push_back(instr_addr_o);
      bus_t.push_back(cyc + lat);
      grants++;
    end else if (instr_req_o && gnt_hold > 0) begin
      gnt_hold--;
    end
    @(negedge clk);
    cyc++;
    if (rst) begin
      bus_a.delete();
      bus_t.delete();
    end
  endtask

  task automatic do_branch(input logic [31:0] t);
    branch_i      = 1'b1;
    branch_addr_i = t;
    sb_branch(t & ~32'h3);
    tick();
    branch_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done          = 1'b0;
    req_i         = 1'b0;
    fetch_ready_i = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (!busy_o && bus_a.size() == 0 && !fetch_valid_o) done = 1'b1;
      else tick();
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    int b;
    rst            = 1'b1;
    req_i          = 1'b0;
    branch_i       = 1'b0;
    branch_addr_i  = '0;
    fetch_ready_i  = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_fetch_addr", fetch_addr_o, 32'h0);
    chk("rst_instr_addr", instr_addr_o, 32'h0);

    // Streaming from a branch target with an always-granting bus
    req_i = 1'b1; fetch_ready_i = 1'b1; lat = 1;
    b = cyc;
    do_branch(32'h0000_0102);
    #1;
    chk("t1_req", 32'(instr_req_o), 32'd1);
    chk("t1_req_addr", instr_addr_o, 32'h0000_0100);
    repeat (10) tick();
    chk("t1_first_valid_cycle", 32'(first_cons), 32'(b + 3));
    chk("t1_three_words", 32'(consumed >= 3), 32'd1);
    drain();

    // IF stage stalled: buffer fills to DEPTH and stops requesting
    req_i = 1'b1; fetch_ready_i = 1'b0;
    grants = 0;
    do_branch(32'h0000_0300);
    repeat (12) tick();
    #1;
    chk("t2_grants", 32'(grants), 32'd4);
    chk("t2_req_low", 32'(instr_req_o), 32'd0);
    chk("t2_busy", 32'(busy_o), 32'd0);
    chk("t2_valid", 32'(fetch_valid_o), 32'd1);
    chk("t2_head_addr", fetch_addr_o, 32'h0000_0300);
    fetch_ready_i = 1'b1;
    tick();
    #1;
    chk("t2_req_after_pop", 32'(instr_req_o), 32'd1);
    drain();

    // Branch with two responses in flight
    exp_q.delete();
    req_i = 1'b0; lat = 4;
    branch_i = 1'b1; branch_addr_i = 32'h0000_0900;
    tick();
    branch_i = 1'b0;
    req_i = 1'b1;
    tick();
    tick();
    #1;
    chk("t3_max_outstanding", 32'(instr_req_o), 32'd0);
    do_branch(32'h0000_0200);
    repeat (16) tick();
    chk("t3_new_words", 32'(consumed >= 4), 32'd1);
    drain();

    // Branch while a request waits for its grant
    exp_q.delete();
    lat = 1;
    branch_i = 1'b1; branch_addr_i = 32'h0000_0500;
    tick();
    branch_i = 1'b0;
    req_i = 1'b1; gnt_hold = 3;
    tick();
    branch_i = 1'b1; branch_addr_i = 32'h0000_0200;
    #1;
    chk("t4_hold_req", 32'(instr_req_o), 32'd1);
    chk("t4_hold_addr_a", instr_addr_o, 32'h0000_0500);
    sb_branch(32'h0000_0200);
    tick();
    branch_i = 1'b0;
    #1;
    chk("t4_hold_addr_b", instr_addr_o, 32'h0000_0500);
    tick();
    #1;
    chk("t4_hold_addr_c", instr_addr_o, 32'h0000_0500);
    tick();
    #1;
    chk("t4_next_req", 32'(instr_req_o), 32'd1);
    chk("t4_next_addr", instr_addr_o, 32'h0000_0200);
    repeat (10) tick();
    chk("t4_new_words", 32'(consumed >= 3), 32'd1);
    drain();

    // Address wrap at the top of memory
    req_i = 1'b1;
    do_branch(32'hFFFF_FFFC);
    #1;
    chk("t5_addr0", instr_addr_o, 32'hFFFF_FFFC);
    tick();
    #1;
    chk("t5_addr1", instr_addr_o, 32'h0000_0000);
    repeat (8) tick();
    chk("t5_words", 32'(consumed >= 3), 32'd1);
    drain();

    // Reset with two transactions outstanding
    req_i = 1'b1; lat = 6;
    do_branch(32'h0000_0700);
    exp_q.delete();
    tick();
    tick();
    #1;
    chk("t6_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1; req_i = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_req", 32'(instr_req_o), 32'd0);
    chk("t6_valid", 32'(fetch_valid_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_fetch_addr", fetch_addr_o, 32'h0);
    repeat (8) tick();
    chk("t6_no_words", 32'(consumed), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
